za_tile_ldst_engine: RTL and testbench
======================================

Name: za_tile_ldst_engine

Overview:
- Initiator for the ZA storage port of the SME2 core. It drives za_addr, za_wdata and za_write_en, and consumes the combinational za_rdata.
- Executes whole-row ZA load (memory -> ZA) and store (ZA -> memory) commands over a valid/ready memory request channel with a separate response channel.
- Sits between the instruction sequencer (command side) and the L1/streaming memory port. One command in flight; one memory transaction outstanding.

Parameters:
- ADDR_W, 48, memory byte-address width.
- ROW_BYTES, 64, memory address stride per ZA row (512 bits).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  engine can accept a command.
- cmd_op  in  1  0 = load into ZA, 1 = store from ZA.
- cmd_base_row  in  8  first ZA row.
- cmd_num_rows  in  9  number of rows, legal range 1..256.
- cmd_mem_addr  in  ADDR_W  first memory byte address.
- za_enabled  in  1  ZA enabled status from the core.
- za_addr  out  8  ZA row address.
- za_wdata  out  512  ZA write data.
- za_write_en  out  1  ZA write strobe.
- za_rdata  in  512  ZA read data, combinational on za_addr.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory request accepted.
- mem_req_we  out  1  1 = write, 0 = read.
- mem_req_addr  out  ADDR_W  request byte address.
- mem_req_wdata  out  512  store data.
- mem_rsp_valid  in  1  read response valid; exactly one per read request; never for writes.
- mem_rsp_rdata  in  512  read response data.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle error pulse, coincident with done.
- rows_xfer  out  9  rows completed for the current or last command.

Behaviour:
- Reset (synchronous, clk edge with rst=1): state IDLE, and every output is 0 except cmd_ready, which goes to 1 on the first cycle after rst deasserts.
- Reset mid-operation abandons the command immediately: no further ZA writes or memory requests; a pending response is ignored.
- Reset applies even while mem_req_valid is high; the memory side must also be reset.
- Internal state: row pointer (8 bit), address pointer (ADDR_W bit), remaining counter (9 bit), store-data register (512 bit), op and abort flags.
- Command accept: cmd_ready = (state == IDLE). Accept on cmd_valid && cmd_ready.
  - If cmd_num_rows == 0 or za_enabled == 0 at accept, go to ERR. Otherwise load the pointers, clear rows_xfer, and go to LD_REQ (op 0) or ST_RD (op 1).
- LD_REQ: mem_req_valid=1, mem_req_we=0, mem_req_addr = address pointer. On mem_req_ready, go to LD_WAIT.
- LD_WAIT: on mem_rsp_valid, same cycle:
  - If za_enabled == 1: za_write_en=1, za_addr = row pointer, za_wdata = mem_rsp_rdata.
  - If za_enabled == 0: no write, set the abort flag.
  - Then row pointer +1 (mod 256), address pointer + ROW_BYTES, remaining -1, rows_xfer +1 (only if written).
  - Next state: DONE if remaining became 0 or abort was set, else LD_REQ.
- ST_RD: za_addr = row pointer; capture za_rdata into the store-data register.
  - If za_enabled == 0, go to DONE with abort set. Otherwise go to ST_REQ.
- ST_REQ: mem_req_valid=1, mem_req_we=1, mem_req_addr = address pointer, mem_req_wdata = store-data register. On mem_req_ready, advance the pointers and counters as for a load, then go to DONE if remaining == 0, else ST_RD.
- Handshake rules:
  - Once mem_req_valid is asserted, it and all payload stay stable until mem_req_ready. It is never withdrawn, even if za_enabled drops.
  - za_addr is 0 outside ST_RD and the LD_WAIT write cycle.
- DONE: done=1 for one cycle, err = abort flag, then IDLE.
- ERR: done=1 and err=1 for one cycle, rows_xfer=0, then IDLE.
- Row wrap: base_row=250 with 10 rows touches rows 250..255 then 0..3.
- Throughput:
  - Load: minimum 2 cycles/row (req + rsp), longer with backpressure or response latency.
  - Store: 2 cycles/row.
  - Command-to-done minimum is 2N+1 cycles after accept, N = rows.
- rows_xfer holds its value after done until the next accept.

Test Plan:
- Load 4 rows, base_row=8, addr=0x1000, mem_req_ready=1, response 2 cycles after request with data 0xA0+i.
  -> Requests at 0x1000/0x1040/0x1080/0x10C0; ZA rows 8..11 written with 0xA0..0xA3; done with err=0; rows_xfer=4.
- Store 3 rows, base_row=254, ZA preloaded with pattern row+1.
  -> ZA read order 254, 255, 0; write requests carry data 255, 256, 1; done after exactly 7 cycles with ready=1.
- Store with mem_req_ready held low 5 cycles on row 1.
  -> mem_req_valid, addr and wdata stay stable for all 5 cycles; no za_addr activity; completion delayed by exactly 5 cycles.
- cmd_num_rows=0, then a separate command with za_enabled=0 at accept.
  -> Each gives done=err=1 the next cycle, no memory or ZA activity, rows_xfer=0.
- Load 8 rows, za_enabled dropped during the row-3 LD_WAIT.
  -> Row-3 response is not written; done=err=1; rows_xfer=3; no further requests.
- rst asserted in LD_WAIT, then a late mem_rsp_valid.
  -> No ZA write; outputs are 0; cmd_ready=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/za_tile_ldst_engine.sv
// Whole-row ZA load/store engine: moves ZA rows to and from memory, one row per
// memory transaction, with one command in flight and one transaction outstanding.
module za_tile_ldst_engine #(
  parameter int ADDR_W    = 48,
  parameter int ROW_BYTES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [7:0]        cmd_base_row,
  input  logic [8:0]        cmd_num_rows,
  input  logic [ADDR_W-1:0] cmd_mem_addr,
  input  logic              za_enabled,
  output logic [7:0]        za_addr,
  output logic [511:0]      za_wdata,
  output logic              za_write_en,
  input  logic [511:0]      za_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [511:0]      mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [511:0]      mem_rsp_rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [8:0]        rows_xfer
);

  typedef enum logic [2:0] {IDLE, LD_REQ, LD_WAIT, ST_RD, ST_REQ, DONE, ERR} state_t;

  state_t            state, next_state;
  logic [7:0]        row_ptr;
  logic [ADDR_W-1:0] addr_ptr;
  logic [8:0]        remaining;
  logic [511:0]      st_data;
  logic              abort;
  logic              accept, ld_beat, st_beat;

  // NOTE: every output and strobe gets a default before the case so no path
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state    = state;
    cmd_ready     = 1'b0;
    za_addr       = '0;
    za_wdata      = '0;
    za_write_en   = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    busy          = 1'b0;
    done          = 1'b0;
    err           = 1'b0;
    accept        = 1'b0;
    ld_beat       = 1'b0;
    st_beat       = 1'b0;
    // Reset silences the ports in the same cycle so an in-flight response cannot write ZA.
    if (!rst) begin
      busy = (state != IDLE);
      unique case (state)
        IDLE: begin
          cmd_ready = 1'b1;
          if (cmd_valid) begin
            accept = 1'b1;
            if (cmd_num_rows == 9'd0 || !za_enabled) next_state = ERR;
            else next_state = cmd_op ? ST_RD : LD_REQ;
          end
        end
        LD_REQ: begin
          mem_req_valid = 1'b1;
          mem_req_addr  = addr_ptr;
          if (mem_req_ready) next_state = LD_WAIT;
        end
        LD_WAIT: begin
          if (mem_rsp_valid) begin
            ld_beat = 1'b1;
            if (za_enabled) begin
              za_write_en = 1'b1;
              za_addr     = row_ptr;
              za_wdata    = mem_rsp_rdata;
            end
            next_state = (remaining == 9'd1 || !za_enabled) ? DONE : LD_REQ;
          end
        end
        ST_RD: begin
          za_addr    = row_ptr;
          next_state = za_enabled ? ST_REQ : DONE;
        end
        ST_REQ: begin
          mem_req_valid = 1'b1;
          mem_req_we    = 1'b1;
          mem_req_addr  = addr_ptr;
          mem_req_wdata = st_data;
          if (mem_req_ready) begin
            st_beat    = 1'b1;
            next_state = (remaining == 9'd1) ? DONE : ST_RD;
          end
        end
        DONE: begin
          done       = 1'b1;
          err        = abort;
          next_state = IDLE;
        end
        ERR: begin
          done       = 1'b1;
          err        = 1'b1;
          next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      row_ptr   <= '0;
      addr_ptr  <= '0;
      remaining <= '0;
      abort     <= 1'b0;
      rows_xfer <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        row_ptr   <= cmd_base_row;
        addr_ptr  <= cmd_mem_addr;
        remaining <= cmd_num_rows;
        abort     <= 1'b0;
        rows_xfer <= '0;
      end
      if (ld_beat || st_beat) begin
        row_ptr   <= row_ptr + 8'd1;
        addr_ptr  <= addr_ptr + ADDR_W'(ROW_BYTES);
        remaining <= remaining - 9'd1;
      end
      if (st_beat || (ld_beat && za_enabled)) rows_xfer <= rows_xfer + 9'd1;
      if ((ld_beat || state == ST_RD) && !za_enabled) abort <= 1'b1;
    end
  end

  // NOTE: the store-data register is pure datapath; it is always written in
  // ST_RD before ST_REQ reads it, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state == ST_RD) st_data <= za_rdata;
  end

endmodule

// File: tb/tb_za_tile_ldst_engine.sv
// Scoreboard bench for za_tile_ldst_engine: a row-level reference model fills
// expectation queues; a negedge monitor pops and compares whatever the DUT emits.
module tb_za_tile_ldst_engine;

  typedef struct {
    logic        we;
    logic [47:0] addr;
    logic [511:0] wdata;
  } req_t;

  typedef struct {
    logic [7:0]   row;
    logic [511:0] data;
  } za_wr_t;

  typedef struct {
    logic       err;
    logic [8:0] rows;
    int         cycles;
  } done_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_ready, cmd_op;
  logic [7:0]   cmd_base_row;
  logic [8:0]   cmd_num_rows;
  logic [47:0]  cmd_mem_addr;
  logic         za_enabled;
  logic [7:0]   za_addr;
  logic [511:0] za_wdata, za_rdata;
  logic         za_write_en;
  logic         mem_req_valid, mem_req_ready, mem_req_we;
  logic [47:0]  mem_req_addr;
  logic [511:0] mem_req_wdata;
  logic         mem_rsp_valid;
  logic [511:0] mem_rsp_rdata;
  logic         busy, done, err;
  logic [8:0]   rows_xfer;

  za_tile_ldst_engine #(.ADDR_W(48), .ROW_BYTES(64)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_base_row(cmd_base_row), .cmd_num_rows(cmd_num_rows), .cmd_mem_addr(cmd_mem_addr),
    .za_enabled(za_enabled), .za_addr(za_addr), .za_wdata(za_wdata),
    .za_write_en(za_write_en), .za_rdata(za_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .busy(busy), .done(done), .err(err), .rows_xfer(rows_xfer)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int acc_cyc = 0;
  int done_seen = 0;

  req_t   exp_req[$];
  za_wr_t exp_za[$];
  done_t  exp_done[$];

  logic [511:0] ref_za [256];
  logic [511:0] za_store [256];
  bit           za_init_done = 0;

  // Stimulus-side configuration, owned by the main process.
  int cmd_seq     = 0;
  int drop_row    = -1;
  int hold_req    = -1;
  int hold_cycles = 0;
  int fixed_lat   = 2;
  bit rand_ready  = 0;
  bit en_cmd      = 1;

  // Memory-side state, owned by the responder.
  int req_count = 0;
  int rd_count  = 0;
  int hold_left = 0;
  bit dropped   = 0;

  assign za_enabled = en_cmd & ~dropped;
  assign za_rdata   = za_store[za_addr];

  function automatic logic [511:0] mem_data(input logic [47:0] a);
    return {16{a[31:0] ^ {16'h5A5A, a[47:32]}}};
  endfunction

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  always @(posedge clk) cyc++;

  // ZA storage array seen by the DUT; written mid-cycle so reads and writes never race the edge.
  always @(negedge clk) begin
    if (!za_init_done) begin
      for (int i = 0; i < 256; i++) za_store[i] = 512'(i + 1);
      za_init_done = 1;
    end else if (za_write_en) begin
      za_store[za_addr] = za_wdata;
    end
  end

  // Memory responder: one response per read handshake after a fixed or random latency.
  initial begin
    int           seen_seq = 0;
    bit           pend = 0;
    int           cnt = 0;
    logic [511:0] pdata = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    forever begin
      @(negedge clk);
      if (cmd_seq != seen_seq) begin
        seen_seq  = cmd_seq;
        req_count = 0;
        rd_count  = 0;
        dropped   = 0;
        hold_left = hold_cycles;
      end
      if (mem_req_valid && !mem_req_ready && hold_left > 0) hold_left--;
      if (!rst && mem_req_valid && mem_req_ready) begin
        req_count++;
        if (!mem_req_we) begin
          pend  = 1;
          cnt   = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 3));
          pdata = mem_data(mem_req_addr);
        end
      end
      @(posedge clk);
      #1;
      mem_rsp_valid = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_rdata = pdata;
          pend = 0;
          if (rd_count == drop_row) dropped = 1;
          rd_count++;
        end
      end
      if (hold_left > 0 && req_count == hold_req) mem_req_ready = 1'b0;
      else if (rand_ready) mem_req_ready = ($urandom_range(0, 3) != 0);
      else mem_req_ready = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every observable DUT event.
  bit           prev_stall = 0;
  logic         prev_we;
  logic [47:0]  prev_addr;
  logic [511:0] prev_wdata;

  always @(negedge clk) begin
    req_t   r;
    za_wr_t z;
    done_t  d;
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (cmd_valid && cmd_ready) acc_cyc = cyc;
      if (prev_stall) begin
        check("req_valid_held", 512'(mem_req_valid), 512'd1);
        check("req_we_stable", 512'(mem_req_we), 512'(prev_we));
        check("req_addr_stable", 512'(mem_req_addr), 512'(prev_addr));
        check("req_wdata_stable", mem_req_wdata, prev_wdata);
      end
      prev_stall = mem_req_valid && !mem_req_ready;
      prev_we    = mem_req_we;
      prev_addr  = mem_req_addr;
      prev_wdata = mem_req_wdata;
      if (mem_req_valid && mem_req_ready) begin
        check("req_expected", 512'(exp_req.size() != 0), 512'd1);
        if (exp_req.size() != 0) begin
          r = exp_req.pop_front();
          check("req_we", 512'(mem_req_we), 512'(r.we));
          check("req_addr", 512'(mem_req_addr), 512'(r.addr));
          if (r.we) check("req_wdata", mem_req_wdata, r.wdata);
        end
      end
      if (za_write_en) begin
        check("za_write_expected", 512'(exp_za.size() != 0), 512'd1);
        if (exp_za.size() != 0) begin
          z = exp_za.pop_front();
          check("za_write_row", 512'(za_addr), 512'(z.row));
          check("za_write_data", za_wdata, z.data);
        end
      end
      if (err) check("err_implies_done", 512'(done), 512'd1);
      if (done) begin
        done_seen++;
        check("busy_during_done", 512'(busy), 512'd1);
        check("done_expected", 512'(exp_done.size() != 0), 512'd1);
        if (exp_done.size() != 0) begin
          d = exp_done.pop_front();
          check("done_err", 512'(err), 512'(d.err));
          check("done_rows_xfer", 512'(rows_xfer), 512'(d.rows));
          if (d.cycles >= 0) check("done_latency", 512'(cyc - acc_cyc), 512'(d.cycles));
        end
      end
    end
  end

  // Reference model: expands a command into its row-level transactions, then offers it.
  task automatic issue(input bit op, input logic [7:0] base, input logic [8:0] num,
                       input logic [47:0] addr, input bit en, input int abort_row,
                       input int cycles);
    logic [47:0] a = addr;
    logic [7:0]  r = base;
    int          n_ok = 0;
    bit          accepted = 0;
    if (num == 9'd0 || !en) begin
      exp_done.push_back(done_t'{1'b1, 9'd0, cycles});
    end else begin
      for (int i = 0; i < int'(num); i++) begin
        if (op) begin
          exp_req.push_back(req_t'{1'b1, a, ref_za[r]});
        end else begin
          exp_req.push_back(req_t'{1'b0, a, 512'd0});
          if (i == abort_row) break;
          ref_za[r] = mem_data(a);
          exp_za.push_back(za_wr_t'{r, mem_data(a)});
        end
        n_ok++;
        r = r + 8'd1;
        a = a + 48'd64;
      end
      exp_done.push_back(done_t'{abort_row >= 0, 9'(n_ok), cycles});
    end
    drop_row = abort_row;
    en_cmd   = en;
    cmd_seq++;
    cmd_op       = op;
    cmd_base_row = base;
    cmd_num_rows = num;
    cmd_mem_addr = addr;
    cmd_valid    = 1'b1;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      accepted = cmd_ready;
      @(posedge clk);
      #1;
    end
    check("cmd_accepted", 512'(accepted), 512'd1);
    cmd_valid = 1'b0;
    en_cmd    = 1'b1;
  endtask

  task automatic wait_done(input int bound);
    int start = done_seen;
    for (int i = 0; i < bound && done_seen == start; i++) @(negedge clk);
    check("done_within_bound", 512'(done_seen != start), 512'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [47:0] ra;
    for (int i = 0; i < 256; i++) ref_za[i] = 512'(i + 1);
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 1'b0;
    cmd_base_row = '0;
    cmd_num_rows = '0;
    cmd_mem_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_cmd_ready", 512'(cmd_ready), 512'd0);
    check("reset_outputs", 512'({mem_req_valid, za_write_en, busy, done, err}), 512'd0);
    check("reset_rows_xfer", 512'(rows_xfer), 512'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 512'(cmd_ready), 512'd1);
    @(posedge clk);
    #1;

    // Load 4 rows, response two cycles after each request: 4*(1+2)+1 cycles.
    fixed_lat = 2;
    issue(1'b0, 8'd8, 9'd4, 48'h1000, 1'b1, -1, 13);
    wait_done(200);

    // Store 3 rows across the row wrap: 2N+1 cycles.
    issue(1'b1, 8'd254, 9'd3, 48'h2000, 1'b1, -1, 7);
    wait_done(200);

    // Store with row 1's request held off for 5 cycles.
    hold_req = 1;
    hold_cycles = 5;
    issue(1'b1, 8'd100, 9'd4, 48'h3000, 1'b1, -1, 14);
    wait_done(200);
    hold_req = -1;
    hold_cycles = 0;

    // Zero rows, then ZA disabled at accept.
    issue(1'b0, 8'd0, 9'd0, 48'h4000, 1'b1, -1, 1);
    wait_done(50);
    issue(1'b1, 8'd0, 9'd5, 48'h4000, 1'b0, -1, 1);
    wait_done(50);

    // Load 8 rows, ZA disabled while row 3's response lands.
    fixed_lat = 1;
    issue(1'b0, 8'd40, 9'd8, 48'h5000, 1'b1, 3, 9);
    wait_done(200);

    // Randomised commands with random backpressure and response latency.
    fixed_lat = 0;
    rand_ready = 1;
    for (int t = 0; t < 25; t++) begin
      ra = {16'($urandom), $urandom};
      issue(1'($urandom_range(0, 1)), 8'($urandom), 9'($urandom_range(0, 10)), ra, 1'b1, -1, -1);
      wait_done(500);
    end
    rand_ready = 0;

    // Reset during LD_WAIT; the late response must not reach ZA.
    fixed_lat = 3;
    issue(1'b0, 8'd60, 9'd6, 48'h6000, 1'b1, -1, -1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready_low", 512'(cmd_ready), 512'd0);
    check("rst_outputs_low", 512'({mem_req_valid, za_write_en, done, err}), 512'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_req.delete();
    exp_za.delete();
    exp_done.delete();
    @(negedge clk);
    check("post_rst_cmd_ready", 512'(cmd_ready), 512'd1);
    check("post_rst_outputs", 512'({mem_req_valid, za_write_en, busy, done, err}), 512'd0);
    check("post_rst_za_addr", 512'(za_addr), 512'd0);
    check("post_rst_rows_xfer", 512'(rows_xfer), 512'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_za_write", 512'(za_write_en), 512'd0);
      check("post_rst_no_req", 512'(mem_req_valid), 512'd0);
    end

    check("req_queue_drained", 512'(exp_req.size()), 512'd0);
    check("za_queue_drained", 512'(exp_za.size()), 512'd0);
    check("done_queue_drained", 512'(exp_done.size()), 512'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
